// File: rtl/ifu_inst_buffer.sv
// Instruction queue between the IFU and the IDU: a small {pc, instr} FIFO.
// Define IBUF_PERF_EN to add push, full-stall and flush performance counters.
module ifu_inst_buffer #(
  parameter int unsigned PC_DW   = 32,
  parameter int unsigned INST_DW = 32,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_DW-1:0]   in_pc,
  input  logic [INST_DW-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_DW-1:0]   out_pc,
  output logic [INST_DW-1:0] out_instr,
  output logic [AW:0]        count
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]        perf_push_cnt,
  output logic [31:0]        perf_full_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  logic [PC_DW-1:0]   pc_mem   [DEPTH];
  logic [INST_DW-1:0] inst_mem [DEPTH];

  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  // Extra pointer MSB tells full apart from empty
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) &&
                 (rd_ptr[AW] != wr_ptr[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = wr_ptr - rd_ptr;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  assign out_pc    = out_valid ? pc_mem[rd_ptr[AW-1:0]]   : '0;
  assign out_instr = out_valid ? inst_mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[AW-1:0]]   <= in_pc;
      inst_mem[wr_ptr[AW-1:0]] <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef IBUF_PERF_EN
  // Counters keep running across flushes; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_push_cnt       <= '0;
      perf_full_stall_cnt <= '0;
      perf_flush_cnt      <= '0;
    end else begin
      if (push)
        perf_push_cnt <= perf_push_cnt + 32'd1;
      if (in_valid && !in_ready)
        perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
      if (flush && (count != '0))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// Directed self-checking bench for ifu_inst_buffer (DEPTH=4).
// Covers reset, fill/stall, drain order, push+pop across wrap and flush.
module tb_ifu_inst_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
`ifdef IBUF_PERF_EN
  logic [31:0] perf_push_cnt;
  logic [31:0] perf_full_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ifu_inst_buffer #(
    .PC_DW  (32),
    .INST_DW(32),
    .DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .count    (count)
`ifdef IBUF_PERF_EN
    ,
    .perf_push_cnt      (perf_push_cnt),
    .perf_full_stall_cnt(perf_full_stall_cnt),
    .perf_flush_cnt     (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    #12 rst = 1'b0;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);

    // single push, visible next cycle
    in_valid = 1'b1;
    in_pc    = 32'h8000_0000;
    in_instr = 32'h0000_0413;
    chk("no_bypass", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("push1_valid", 64'(out_valid), 64'd1);
    chk("push1_pc", 64'(out_pc), 64'h8000_0000);
    chk("push1_instr", 64'(out_instr), 64'h0000_0413);
    chk("push1_count", 64'(count), 64'd1);

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    #1 rst = 1'b0;
    tick();

    // fill and stall: 5 offered, 4 accepted
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h8000_0000 + 32'(4 * i);
      in_instr = 32'h100 + 32'(i);
      chk($sformatf("fill_in_ready%0d", i), 64'(in_ready),
          64'(i < 4));
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
`ifdef IBUF_PERF_EN
    chk("perf_push_fill", 64'(perf_push_cnt), 64'd4);
    chk("perf_stall_fill", 64'(perf_full_stall_cnt), 64'd1);
`endif

    // drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("drain_pc%0d", i), 64'(out_pc),
          64'(32'h8000_0000 + 32'(4 * i)));
      chk($sformatf("drain_instr%0d", i), 64'(out_instr),
          64'(32'h100 + 32'(i)));
      tick();
    end
    out_ready = 1'b0;
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_valid", 64'(out_valid), 64'd0);

    // push/pop together at count=2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h1000 + 32'(4 * i);
      in_instr = 32'h200 + 32'(i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      in_valid  = 1'b1;
      in_pc     = 32'h1000 + 32'(4 * (k + 2));
      in_instr  = 32'h200 + 32'(k + 2);
      out_ready = 1'b1;
      chk($sformatf("pp_count%0d", k), 64'(count), 64'd2);
      chk($sformatf("pp_pc%0d", k), 64'(out_pc),
          64'(32'h1000 + 32'(4 * k)));
      tick();
    end
    out_ready = 1'b0;
    in_pc     = 32'h1000 + 32'd48;
    in_instr  = 32'h200 + 32'd12;
    chk("pp_end_count", 64'(count), 64'd2);
    chk("pp_end_pc", 64'(out_pc), 64'h1028);
    tick();
    chk("pre_flush_count", 64'(count), 64'd3);

    // flush with concurrent push (discarded)
    flush    = 1'b1;
    in_pc    = 32'h8000_0100;
    in_instr = 32'h300;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_pc", 64'(out_pc), 64'd0);

    in_valid = 1'b1;
    in_pc    = 32'h8000_0200;
    in_instr = 32'h400;
    tick();
    in_valid = 1'b0;
    chk("post_flush_pc", 64'(out_pc), 64'h8000_0200);
    chk("post_flush_instr", 64'(out_instr), 64'h400);
    chk("post_flush_count", 64'(count), 64'd1);

    // flush at count=1, then flush while empty
    flush = 1'b1;
    tick();
    chk("flush1_count", 64'(count), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_empty_count", 64'(count), 64'd0);
    chk("flush_empty_valid", 64'(out_valid), 64'd0);
`ifdef IBUF_PERF_EN
    chk("perf_push_end", 64'(perf_push_cnt), 64'd18);
    chk("perf_stall_end", 64'(perf_full_stall_cnt), 64'd1);
    chk("perf_flush_end", 64'(perf_flush_cnt), 64'd2);
`endif

    // empty: out_ready ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_pop_count", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_inst_buffer.md
Name: ifu_inst_buffer

Overview:
- Instruction queue directly downstream of the IFU.
- Accepts fetched {pc, instr} pairs from the IFU over a valid/ready handshake and buffers them in a small FIFO.
- Presents the oldest pair to the IDU.
- Decouples fetch from decode stalls; flushes all contents on a redirect (branch, jump or trap) from EXU/WBU.

Parameters:
- PC_DW, 32, width of a program counter.
- INST_DW, 32, width of an instruction word.
- DEPTH, 4, number of entries; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  discard all entries this cycle (redirect).
- in_valid  input  1  IFU presents a pair.
- in_ready  output  1  buffer can accept a pair.
- in_pc  input  PC_DW  PC of the fetched instruction.
- in_instr  input  INST_DW  fetched instruction.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  IDU consumes the head.
- out_pc  output  PC_DW  PC of the head entry.
- out_instr  output  INST_DW  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage:
  - DEPTH entries of {pc, instr}; storage array is not reset.
  - rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - empty = (rd_ptr == wr_ptr).
  - full = (low bits equal) && (MSBs differ).
- Reset:
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 1, out_pc = 0, out_instr = 0.
- Push: in_valid && in_ready && !flush writes {in_pc, in_instr} at wr_ptr; wr_ptr increments with natural wrap.
- Pop: out_valid && out_ready && !flush; rd_ptr increments with natural wrap.
- Handshake outputs:
  - in_ready = !full. It is combinational from state only and never depends on out_ready, so there is no full-time pass-through.
  - out_valid = !empty.
  - out_pc/out_instr = head entry when out_valid = 1, else 0.
- Latency: a pair pushed in cycle N is visible at the output in cycle N+1 at the earliest. There is no same-cycle bypass.
- Simultaneous push and pop: both occur; count is unchanged. This is legal at any non-empty, non-full occupancy.
- Full: in_ready = 0. The IFU must hold in_pc/in_instr stable until accepted.
- Empty: out_valid = 0. out_ready is ignored.
- Flush:
  - Next edge sets rd_ptr = wr_ptr = 0 and count = 0.
  - Any same-cycle push or pop is discarded.
  - In the cycle after flush: out_valid = 0, in_ready = 1.
  - Flush while empty is a no-op beyond the pointer reset.
- Reset mid-operation: asynchronous clear to the reset values above, independent of clk. Contents are lost.
- Ordering: strict FIFO. No entry is duplicated or dropped except by flush.
- Wrap-around: pointers wrap modulo 2*DEPTH. Occupancy = wr_ptr - rd_ptr, computed in pointer width.

Optional Feature:
- Macro: IBUF_PERF_EN.
- Defined: adds three output ports, each 32 bits, wrapping, reset to 0:
  - perf_push_cnt: accepted pushes.
  - perf_full_stall_cnt: cycles with in_valid && !in_ready.
  - perf_flush_cnt: cycles with flush = 1 and count != 0.
  - Counters ignore flush themselves and are cleared only by rst.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset then idle, DEPTH=4:
  - rst pulse asynchronously mid-cycle -> out_valid=0, in_ready=1, count=0, out_pc=0 immediately.
- Single push:
  - push pc=0x80000000, instr=0x00000413 with out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_instr=0x00000413, count=1.
- Fill and stall:
  - push 5 consecutive pairs (pc 0x80000000..0x80000010, step 4) with out_ready=0 -> first 4 accepted, count=4, in_ready=0 during the 5th.
  - Then drain with out_ready=1 -> pcs emerge in order 0x80000000..0x8000000C.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2 and the output PC sequence is gap-free across pointer wrap.
- Flush with count=3 plus a concurrent push of pc=0x80000100 -> next cycle count=0, out_valid=0.
  - The following push of pc=0x80000200 is the next output.
- IBUF_PERF_EN defined; run the fill-and-stall scenario plus one flush at count=1 -> perf_push_cnt=4, perf_full_stall_cnt>=1 (exact stall-cycle count checked), perf_flush_cnt=1.
